id_decode_stage: RTL and testbench

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/imm_gen.sv | 32 +++
 rtl/id_decode_stage.sv | 209 ++++++++++++++++++++
 tb/tb_id_decode_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: ALU operation codes, major opcodes, immediate
// format selects and the funct3 -> base ALU operation mapping.
// Used by the decode stage and the ALU.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  // funct3 -> operation when funct7 selects the base (non-alternate) form
  function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_alu_op = ALU_ADD;
      3'b001:  base_alu_op = ALU_SLL;
      3'b010:  base_alu_op = ALU_SLT;
      3'b011:  base_alu_op = ALU_SLTU;
      3'b100:  base_alu_op = ALU_XOR;
      3'b101:  base_alu_op = ALU_SRL;
      3'b110:  base_alu_op = ALU_OR;
      default: base_alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J (or shift-amount) immediate
// from an instruction word and sign-extends it from instr[31] to XLEN.
//   instr : instruction bits [31:7] (opcode bits carry no immediate content)
//   sel   : immediate format select
//   imm   : sign-extended immediate, zero when sel is IMM_NONE
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_sel_e        sel,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (sel)
      IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_SHAMT: imm32 = {27'd0, instr[24:20]};
      IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm32 = {instr[31:12], 12'd0};
      IMM_J:     imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/id_decode_stage.sv
// RV32 instruction decode stage with a single-entry output pipeline register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : handshake from fetch; in_instr, in_pc payload
//   flush               : drops the held bundle and any same-cycle input
//   out_valid/out_ready : handshake to execute
//   out_*               : registered decoded bundle (ALU op, register
//                         indices, immediate, control flags, funct3, pc,
//                         illegal-encoding flag)
module id_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_a_is_pc,
  output logic            out_reg_write,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    alu_op_e         alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_imm;
    logic            a_is_pc;
    logic            reg_write;
    logic            is_branch;
    logic            is_jump;
    logic            is_load;
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } bundle_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            illegal;
  imm_sel_e        imm_sel;
  logic [XLEN-1:0] imm;
  bundle_t         dec;
  bundle_t         q;
  logic [XLEN-1:0] q_imm;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .sel   (imm_sel),
    .imm   (imm)
  );

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.funct3 = funct3;
    dec.pc     = in_pc;
    imm_sel    = IMM_NONE;
    illegal    = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec.reg_write = 1'b1;
          if (funct7 == F7_BASE)                       dec.alu_op = base_alu_op(funct3);
          else if (funct7 == F7_ALT && funct3 == 3'b000) dec.alu_op = ALU_SUB;
          else if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = ALU_SRA;
          else                                         illegal = 1'b1;
        end
        OPC_OP_IMM: begin
          dec.reg_write = 1'b1;
          dec.use_imm   = 1'b1;
          imm_sel       = IMM_I;
          dec.alu_op    = base_alu_op(funct3);
          // shifts carry funct7 in the upper immediate bits; the operand is shamt only
          if (funct3 == 3'b001) begin
            imm_sel = IMM_SHAMT;
            if (funct7 != F7_BASE) illegal = 1'b1;
          end else if (funct3 == 3'b101) begin
            imm_sel = IMM_SHAMT;
            if (funct7 == F7_ALT)       dec.alu_op = ALU_SRA;
            else if (funct7 != F7_BASE) illegal = 1'b1;
          end
        end
        OPC_LUI: begin
          dec.rs1       = '0;
          dec.use_imm   = 1'b1;
          dec.reg_write = 1'b1;
          imm_sel       = IMM_U;
        end
        OPC_AUIPC: begin
          dec.a_is_pc   = 1'b1;
          dec.use_imm   = 1'b1;
          dec.reg_write = 1'b1;
          imm_sel       = IMM_U;
        end
        OPC_BRANCH: begin
          dec.alu_op    = ALU_SUB;
          dec.is_branch = 1'b1;
          imm_sel       = IMM_B;
          if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
        end
        OPC_LOAD: begin
          dec.use_imm   = 1'b1;
          dec.is_load   = 1'b1;
          dec.reg_write = 1'b1;
          imm_sel       = IMM_I;
        end
        OPC_STORE: begin
          dec.use_imm  = 1'b1;
          dec.is_store = 1'b1;
          imm_sel      = IMM_S;
        end
        OPC_JAL: begin
          dec.a_is_pc   = 1'b1;
          dec.use_imm   = 1'b1;
          dec.is_jump   = 1'b1;
          dec.reg_write = 1'b1;
          imm_sel       = IMM_J;
        end
        OPC_JALR: begin
          dec.use_imm   = 1'b1;
          dec.is_jump   = 1'b1;
          dec.reg_write = 1'b1;
          imm_sel       = IMM_I;
          if (funct3 != 3'b000) illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
    // an illegal encoding still flows down the pipe, but as an inert ADD
    if (illegal) begin
      dec.alu_op    = ALU_ADD;
      dec.use_imm   = 1'b0;
      dec.a_is_pc   = 1'b0;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jump   = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      imm_sel       = IMM_NONE;
    end
    dec.illegal = illegal;
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      q_imm     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      q         <= dec;
      q_imm     <= imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_alu_op    = q.alu_op;
  assign out_rs1       = q.rs1;
  assign out_rs2       = q.rs2;
  assign out_rd        = q.rd;
  assign out_imm       = q_imm;
  assign out_use_imm   = q.use_imm;
  assign out_a_is_pc   = q.a_is_pc;
  assign out_reg_write = q.reg_write;
  assign out_is_branch = q.is_branch;
  assign out_is_jump   = q.is_jump;
  assign out_is_load   = q.is_load;
  assign out_is_store  = q.is_store;
  assign out_funct3    = q.funct3;
  assign out_pc        = q.pc;
  assign out_illegal   = q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: reset values, a directed vector
// table, stall/flush/reset sequences, and randomized traffic against a
// behavioural decode model with a one-entry queue as the pipeline model.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_use_imm, out_a_is_pc, out_reg_write, out_is_branch;
  logic        out_is_jump, out_is_load, out_is_store;
  logic [2:0]  out_funct3;
  logic [31:0] out_pc;
  logic        out_illegal;

  id_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_a_is_pc(out_a_is_pc),
    .out_reg_write(out_reg_write), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_funct3(out_funct3), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        imm_chk;
    logic        use_imm, a_is_pc, rw, br, jmp, ld, st, ill;
    logic [2:0]  f3;
    logic [31:0] pc;
  } exp_t;

  // ALU code for the base (funct7 = 0) form of each funct3
  int unsigned base_op [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic legal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = $signed(i) >>> 20;
    imm_s = (imm_i & ~32'h1F) | 32'(i[11:7]);
    imm_b = (i[31] ? 32'hFFFFF000 : 32'h0) + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
    imm_u = i & 32'hFFFFF000;
    imm_j = (i[31] ? 32'hFFF00000 : 32'h0) + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
    e = '{alu: 4'd0, rs1: i[19:15], rs2: i[24:20], rd: i[11:7], imm: 32'h0, imm_chk: 1'b0,
          use_imm: 1'b0, a_is_pc: 1'b0, rw: 1'b0, br: 1'b0, jmp: 1'b0, ld: 1'b0, st: 1'b0,
          ill: 1'b0, f3: i[14:12], pc: pc};
    legal = (i[1:0] == 2'b11);
    if (legal) begin
      case (i[6:0])
        7'h33: begin
          e.rw = 1;
          if (i[31:25] == 0) e.alu = 4'(base_op[i[14:12]]);
          else if (i[31:25] == 7'h20 && i[14:12] == 0) e.alu = 4'd1;
          else if (i[31:25] == 7'h20 && i[14:12] == 5) e.alu = 4'd7;
          else legal = 0;
        end
        7'h13: begin
          e.rw = 1; e.use_imm = 1; e.imm_chk = 1;
          if (i[14:12] == 1) begin
            e.alu = 4'd2; e.imm = 32'(i[24:20]); legal = (i[31:25] == 0);
          end else if (i[14:12] == 5) begin
            e.imm = 32'(i[24:20]);
            if (i[31:25] == 0) e.alu = 4'd6;
            else if (i[31:25] == 7'h20) e.alu = 4'd7;
            else legal = 0;
          end else begin
            e.alu = 4'(base_op[i[14:12]]); e.imm = imm_i;
          end
        end
        7'h37: begin e.rs1 = 0; e.use_imm = 1; e.rw = 1; e.imm = imm_u; e.imm_chk = 1; end
        7'h17: begin e.a_is_pc = 1; e.use_imm = 1; e.rw = 1; e.imm = imm_u; e.imm_chk = 1; end
        7'h63: begin
          e.alu = 4'd1; e.br = 1; e.imm = imm_b; e.imm_chk = 1;
          legal = !(i[14:12] == 2 || i[14:12] == 3);
        end
        7'h03: begin e.use_imm = 1; e.ld = 1; e.rw = 1; e.imm = imm_i; e.imm_chk = 1; end
        7'h23: begin e.use_imm = 1; e.st = 1; e.imm = imm_s; e.imm_chk = 1; end
        7'h6F: begin e.a_is_pc = 1; e.use_imm = 1; e.jmp = 1; e.rw = 1; e.imm = imm_j; e.imm_chk = 1; end
        7'h67: begin
          e.use_imm = 1; e.jmp = 1; e.rw = 1; e.imm = imm_i; e.imm_chk = 1;
          legal = (i[14:12] == 0);
        end
        default: legal = 0;
      endcase
    end
    if (!legal) begin
      e.alu = 0; e.use_imm = 0; e.a_is_pc = 0; e.rw = 0; e.br = 0; e.jmp = 0;
      e.ld = 0; e.st = 0; e.ill = 1; e.imm_chk = 0;
    end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  task automatic check_bundle(input string p, input exp_t e);
    chk({p, "_alu_op"}, 32'(out_alu_op), 32'(e.alu));
    chk({p, "_rs1"}, 32'(out_rs1), 32'(e.rs1));
    chk({p, "_rs2"}, 32'(out_rs2), 32'(e.rs2));
    chk({p, "_rd"}, 32'(out_rd), 32'(e.rd));
    if (e.imm_chk) chk({p, "_imm"}, out_imm, e.imm);
    chk({p, "_flags"}, {24'd0, out_use_imm, out_a_is_pc, out_reg_write, out_is_branch,
        out_is_jump, out_is_load, out_is_store, out_illegal},
        {24'd0, e.use_imm, e.a_is_pc, e.rw, e.br, e.jmp, e.ld, e.st, e.ill});
    chk({p, "_funct3"}, 32'(out_funct3), 32'(e.f3));
    chk({p, "_pc"}, out_pc, e.pc);
  endtask

  logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h67};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        imm_chk, use_imm, rw, ill;
  } vec_t;

  function automatic vec_t mkv(input logic [31:0] instr, input logic [3:0] alu,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] imm, input logic imm_chk, input logic use_imm,
                               input logic rw, input logic ill);
    vec_t v;
    v = '{instr: instr, alu: alu, rs1: rs1, rs2: rs2, rd: rd, imm: imm,
          imm_chk: imm_chk, use_imm: use_imm, rw: rw, ill: ill};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    exp_t q [$];
    exp_t nxt;
    logic acc, drn, rdy_exp;

    vecs[0] = mkv(32'h002081B3, 4'd0, 5'd1, 5'd2,  5'd3, 32'h0,        0, 0, 1, 0);
    vecs[1] = mkv(32'h407302B3, 4'd1, 5'd6, 5'd7,  5'd5, 32'h0,        0, 0, 1, 0);
    vecs[2] = mkv(32'h40315093, 4'd7, 5'd2, 5'd3,  5'd1, 32'h3,        1, 1, 1, 0);
    vecs[3] = mkv(32'hFFF00093, 4'd0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 1, 1, 1, 0);
    vecs[4] = mkv(32'h00000000, 4'd0, 5'd0, 5'd0,  5'd0, 32'h0,        0, 0, 0, 1);
    vecs[5] = mkv(32'h00000033, 4'd0, 5'd0, 5'd0,  5'd0, 32'h0,        0, 0, 0, 0);
    vecs[6] = mkv(32'h123450B7, 4'd0, 5'd0, 5'd3,  5'd1, 32'h12345000, 1, 1, 1, 0);
    vecs[7] = mkv(32'h00002063, 4'd0, 5'd0, 5'd0,  5'd0, 32'h0,        0, 0, 0, 1);
    vecs[8] = mkv(32'hFE000EE3, 4'd1, 5'd0, 5'd0,  5'd29, 32'hFFFFFFFC, 1, 0, 0, 0);

    rst = 1; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_alu_op", 32'(out_alu_op), 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_flags", {24'd0, out_use_imm, out_a_is_pc, out_reg_write, out_is_branch,
        out_is_jump, out_is_load, out_is_store, out_illegal}, 0);

    // directed table, back-to-back with out_ready held high
    for (int k = 0; k < 9; k++) begin
      in_valid = 1; in_instr = vecs[k].instr; in_pc = 32'h1000 + 32'(4 * k);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("v%0d_alu_op", k), 32'(out_alu_op), 32'(vecs[k].alu));
      chk($sformatf("v%0d_rs1", k), 32'(out_rs1), 32'(vecs[k].rs1));
      chk($sformatf("v%0d_rs2", k), 32'(out_rs2), 32'(vecs[k].rs2));
      chk($sformatf("v%0d_rd", k), 32'(out_rd), 32'(vecs[k].rd));
      if (vecs[k].imm_chk) chk($sformatf("v%0d_imm", k), out_imm, vecs[k].imm);
      chk($sformatf("v%0d_use_imm", k), 32'(out_use_imm), 32'(vecs[k].use_imm));
      chk($sformatf("v%0d_reg_write", k), 32'(out_reg_write), 32'(vecs[k].rw));
      chk($sformatf("v%0d_illegal", k), 32'(out_illegal), 32'(vecs[k].ill));
      chk($sformatf("v%0d_pc", k), out_pc, 32'h1000 + 32'(4 * k));
    end

    // stall for 3 cycles holding ADD x3, then release with back-to-back accepts
    in_instr = 32'h002081B3; in_pc = 32'h2000;
    @(posedge clk); #1;
    out_ready = 0; in_instr = 32'h407302B3; in_pc = 32'h2004;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("stall%0d_rd", k), 32'(out_rd), 3);
      chk($sformatf("stall%0d_alu_op", k), 32'(out_alu_op), 0);
      chk($sformatf("stall%0d_pc", k), out_pc, 32'h2000);
    end
    out_ready = 1;
    #1 chk("release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("release_valid", 32'(out_valid), 1);
    chk("release_alu_op", 32'(out_alu_op), 1);
    chk("release_pc", out_pc, 32'h2004);
    in_instr = 32'h40315093; in_pc = 32'h2008;
    @(posedge clk); #1;
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_alu_op", 32'(out_alu_op), 7);
    chk("b2b_pc", out_pc, 32'h2008);

    // flush with a held bundle and a same-cycle input
    out_ready = 0; in_instr = 32'hFFF00093; in_pc = 32'h200C; flush = 1;
    @(posedge clk); #1;
    chk("flush_valid", 32'(out_valid), 0);
    flush = 0; in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("flush_dropped", 32'(out_valid), 0);

    // reset while a bundle is held and input is offered
    in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h3000; out_ready = 0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1; in_instr = 32'h407302B3;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_rd", 32'(out_rd), 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & ~32'h3;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      #1;
      rdy_exp = (q.size() == 0) || out_ready;
      chk("rnd_in_ready", 32'(in_ready), 32'(rdy_exp));
      acc = in_valid && rdy_exp && !flush;
      drn = (q.size() != 0) && out_ready;
      nxt = ref_decode(in_instr, in_pc);
      @(posedge clk); #1;
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(nxt);
      end
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check_bundle("rnd", q[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
